// File: rtl/mcu_pkg.sv
// Shared MCU definitions: opcode values, the 3-bit instruction phase encoding
// and small decode helpers used by the sequencer, the datapath and the benches.
package mcu_pkg;

  typedef enum logic [2:0] {
    PH_IADDR  = 3'd0,
    PH_IFETCH = 3'd1,
    PH_ILOAD  = 3'd2,
    PH_IDLE   = 3'd3,
    PH_OADDR  = 3'd4,
    PH_OFETCH = 3'd5,
    PH_ALU    = 3'd6,
    PH_STORE  = 3'd7
  } phase_t;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  function automatic logic is_aluop(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

  function automatic phase_t next_phase(input phase_t ph);
    case (ph)
      PH_IADDR:  return PH_IFETCH;
      PH_IFETCH: return PH_ILOAD;
      PH_ILOAD:  return PH_IDLE;
      PH_IDLE:   return PH_OADDR;
      PH_OADDR:  return PH_OFETCH;
      PH_OFETCH: return PH_ALU;
      PH_ALU:    return PH_STORE;
      default:   return PH_IADDR;
    endcase
  endfunction

endpackage

// File: rtl/mcu_ctrl_decode.sv
// Combinational control decode: phase, opcode, zero flag and halt state to
// the nine datapath loads, enables and memory strobes.
module mcu_ctrl_decode
  import mcu_pkg::*;
(
  input  logic [2:0] i_phase,
  input  logic [2:0] i_op,
  input  logic       i_legal,
  input  logic       i_zero,
  input  logic       i_halt_q,
  output logic       o_sel,
  output logic       o_rd,
  output logic       o_wr,
  output logic       o_ld_ir,
  output logic       o_ld_acc,
  output logic       o_ld_mdr,
  output logic       o_ld_pc,
  output logic       o_inc,
  output logic       o_dout_en
);

  logic w_alu;
  logic w_sto;
  logic w_jmp;
  logic w_skz;

  // Illegal opcodes clear every class flag, so phases 5-7 decode as a NOP.
  assign w_alu = i_legal && is_aluop(i_op);
  assign w_sto = i_legal && (i_op == OP_STO);
  assign w_jmp = i_legal && (i_op == OP_JMP);
  assign w_skz = i_legal && (i_op == OP_SKZ);

  always_comb begin
    o_sel     = 1'b0;
    o_rd      = 1'b0;
    o_wr      = 1'b0;
    o_ld_ir   = 1'b0;
    o_ld_acc  = 1'b0;
    o_ld_mdr  = 1'b0;
    o_ld_pc   = 1'b0;
    o_inc     = 1'b0;
    o_dout_en = 1'b0;
    if (i_halt_q) begin
      o_sel = 1'b1;
    end else begin
      case (phase_t'(i_phase))
        PH_IADDR:  o_sel = 1'b1;
        PH_IFETCH: begin
          o_sel = 1'b1;
          o_rd  = 1'b1;
        end
        PH_ILOAD:  begin
          o_sel    = 1'b1;
          o_rd     = 1'b1;
          o_ld_ir  = 1'b1;
          o_ld_mdr = 1'b1;
        end
        PH_IDLE:   begin
          o_sel   = 1'b1;
          o_rd    = 1'b1;
          o_ld_ir = 1'b1;
        end
        PH_OADDR:  o_inc = 1'b1;
        PH_OFETCH: o_rd = w_alu;
        PH_ALU:    begin
          o_rd      = w_alu;
          o_ld_mdr  = w_alu;
          o_inc     = w_skz && i_zero;
          o_ld_pc   = w_jmp;
          o_dout_en = w_sto;
        end
        PH_STORE:  begin
          o_rd      = w_alu;
          o_ld_acc  = w_alu;
          o_ld_pc   = w_jmp;
          o_dout_en = w_sto;
          o_wr      = w_sto;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mcu_sequencer.sv
// Instruction sequencer: owns the phase register, memory wait states,
// latched halt with restart, and illegal-opcode detection.
module mcu_sequencer
  import mcu_pkg::*;
#(
  parameter int unsigned OP_W        = 3,
  parameter bit          MEM_WAIT_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] op,
  input  logic            zero,
  input  logic            mem_rdy,
  input  logic            go,
  output logic            sel,
  output logic            rd,
  output logic            wr,
  output logic            ld_ir,
  output logic            ld_acc,
  output logic            ld_mdr,
  output logic            ld_pc,
  output logic            inc,
  output logic            dout_en,
  output logic            halt,
  output logic            illegal,
  output logic [2:0]      pstate
);

  phase_t     r_phase;
  logic       r_halt;
  logic [2:0] w_op;
  logic       w_legal;
  logic       w_mem_phase;
  logic       w_stall;

  assign w_op    = op[2:0];
  assign w_legal = ((op >> 3) == '0);

  // Only phases that actually touch memory for this opcode wait on mem_rdy.
  always_comb begin
    w_mem_phase = 1'b0;
    case (r_phase)
      PH_IFETCH: w_mem_phase = 1'b1;
      PH_OFETCH: w_mem_phase = w_legal && is_aluop(w_op);
      PH_STORE:  w_mem_phase = w_legal && (w_op == OP_STO);
      default:   w_mem_phase = 1'b0;
    endcase
  end

  assign w_stall = MEM_WAIT_EN && w_mem_phase && !mem_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= PH_IADDR;
      r_halt  <= 1'b0;
    end else if (r_halt) begin
      if (go) r_halt <= 1'b0;
    end else if (!w_stall) begin
      if (r_phase == PH_OADDR && w_legal && w_op == OP_HLT) begin
        r_halt  <= 1'b1;
        r_phase <= PH_IADDR;
      end else begin
        r_phase <= next_phase(r_phase);
      end
    end
  end

  mcu_ctrl_decode u_decode (
    .i_phase   (r_phase),
    .i_op      (w_op),
    .i_legal   (w_legal),
    .i_zero    (zero),
    .i_halt_q  (r_halt),
    .o_sel     (sel),
    .o_rd      (rd),
    .o_wr      (wr),
    .o_ld_ir   (ld_ir),
    .o_ld_acc  (ld_acc),
    .o_ld_mdr  (ld_mdr),
    .o_ld_pc   (ld_pc),
    .o_inc     (inc),
    .o_dout_en (dout_en)
  );

  assign halt    = r_halt;
  assign illegal = (r_phase == PH_OADDR) && !w_legal && !r_halt;
  assign pstate  = r_phase;

endmodule

// File: tb/tb_mcu_sequencer.sv
// Self-checking bench for mcu_sequencer (OP_W=5) against a cycle-level
// reference model built from the phase/opcode rules.
module tb_mcu_sequencer;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst, zero, mem_rdy, go;
  logic [W-1:0] op;
  logic         sel, rd, wr, ld_ir, ld_acc, ld_mdr, ld_pc, inc, dout_en, halt, illegal;
  logic [2:0]   pstate;
  logic [10:0]  w_obs;

  int n_vec  = 0;
  int n_fail = 0;
  int m_ph   = 0;
  bit m_hq   = 1'b0;

  localparam logic [10:0] RESET_OBS  = 11'b100_0000_0000;
  localparam logic [10:0] HALTED_OBS = 11'b100_0000_0010;

  always #5 clk = ~clk;

  assign w_obs = {sel, rd, wr, ld_ir, ld_acc, ld_mdr, ld_pc, inc, dout_en, halt, illegal};

  mcu_sequencer #(.OP_W(W), .MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_rdy(mem_rdy), .go(go),
    .sel(sel), .rd(rd), .wr(wr), .ld_ir(ld_ir), .ld_acc(ld_acc), .ld_mdr(ld_mdr),
    .ld_pc(ld_pc), .inc(inc), .dout_en(dout_en), .halt(halt), .illegal(illegal),
    .pstate(pstate)
  );

  // Expected {sel,rd,wr,ld_ir,ld_acc,ld_mdr,ld_pc,inc,dout_en,halt,illegal}.
  function automatic logic [10:0] exp_ctrl(int ph, bit hq, logic [W-1:0] o5, logic z);
    logic [2:0] o;
    logic legal, alu, sto, jmp, skz;
    o     = o5[2:0];
    legal = (o5[4:3] == 2'b00);
    alu   = legal && (o inside {[3'd2:3'd5]});
    sto   = legal && (o == 3'd6);
    jmp   = legal && (o == 3'd7);
    skz   = legal && (o == 3'd1);
    if (hq) return HALTED_OBS;
    return {ph <= 3, (ph >= 1 && ph <= 3) || (ph >= 5 && alu), ph == 7 && sto,
            ph == 2 || ph == 3, ph == 7 && alu, ph == 2 || (ph == 6 && alu),
            (ph == 6 || ph == 7) && jmp, ph == 4 || (ph == 6 && skz && z),
            (ph == 6 || ph == 7) && sto, 1'b0, ph == 4 && !legal};
  endfunction

  task automatic tick();
    int nph;
    bit nhq, legal, stall;
    logic [2:0] o;
    nph   = m_ph;
    nhq   = m_hq;
    o     = op[2:0];
    legal = (op[4:3] == 2'b00);
    stall = !m_hq && !mem_rdy && (m_ph == 1 ||
            (m_ph == 5 && legal && (o inside {[3'd2:3'd5]})) ||
            (m_ph == 7 && legal && o == 3'd6));
    if (rst) begin
      nph = 0;
      nhq = 1'b0;
    end else if (m_hq) begin
      if (go) nhq = 1'b0;
    end else if (stall) begin
      nph = m_ph;
    end else if (m_ph == 4 && legal && o == 3'd0) begin
      nhq = 1'b1;
      nph = 0;
    end else begin
      nph = (m_ph + 1) % 8;
    end
    @(posedge clk);
    #1;
    m_ph = nph;
    m_hq = nhq;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    go  = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; go = 1'b1; mem_rdy = 1'b0; op = 5'd2; zero = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++;
      if (pstate !== 3'd0 || w_obs !== RESET_OBS) begin
        n_fail++;
        $display("FAIL reset: got pstate=%0d ctrl=%b, want pstate=0 ctrl=%b", pstate, w_obs, RESET_OBS);
      end
    end
    rst = 1'b0; go = 1'b0;
  endtask

  task automatic test_add_run();
    do_reset();
    op = 5'd2; mem_rdy = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      zero = 1'($urandom);
      tick();
      n_vec++;
      if (pstate !== 3'(i % 8) || ld_acc !== (i % 8 == 7) ||
          w_obs !== exp_ctrl(m_ph, m_hq, op, zero)) begin
        n_fail++;
        $display("FAIL add_run i=%0d: got pstate=%0d ctrl=%b, want pstate=%0d ctrl=%b",
                 i, pstate, w_obs, i % 8, exp_ctrl(m_ph, m_hq, op, zero));
      end
    end
  endtask

  task automatic test_skz();
    logic [7:0] mask;
    for (int z = 1; z >= 0; z--) begin
      do_reset();
      op = 5'd1; mem_rdy = 1'b1; zero = 1'(z);
      mask = '0;
      for (int i = 1; i <= 8; i++) begin
        tick();
        if (inc === 1'b1) mask[pstate] = 1'b1;
        n_vec++;
        if (w_obs !== exp_ctrl(m_ph, m_hq, op, zero)) begin
          n_fail++;
          $display("FAIL skz z=%0d i=%0d: got ctrl=%b, want %b", z, i, w_obs, exp_ctrl(m_ph, m_hq, op, zero));
        end
      end
      n_vec++;
      if (mask !== (z == 1 ? 8'b0101_0000 : 8'b0001_0000)) begin
        n_fail++;
        $display("FAIL skz_inc z=%0d: got inc phases=%b, want %b", z, mask,
                 (z == 1 ? 8'b0101_0000 : 8'b0001_0000));
      end
    end
  endtask

  task automatic test_sto_stall();
    do_reset();
    op = 5'd6; mem_rdy = 1'b1; zero = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    mem_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (pstate !== 3'd7 || wr !== 1'b1 || dout_en !== 1'b1 ||
          w_obs !== exp_ctrl(m_ph, m_hq, op, zero)) begin
        n_fail++;
        $display("FAIL sto_stall cyc=%0d: got pstate=%0d wr=%b dout_en=%b, want pstate=7 wr=1 dout_en=1",
                 i, pstate, wr, dout_en);
      end
      if (i < 3) tick();
    end
    mem_rdy = 1'b1;
    tick();
    n_vec++;
    if (pstate !== 3'd0 || w_obs !== exp_ctrl(m_ph, m_hq, op, zero)) begin
      n_fail++;
      $display("FAIL sto_resume: got pstate=%0d, want 0", pstate);
    end
  endtask

  task automatic test_halt();
    do_reset();
    op = 5'd0; mem_rdy = 1'b1; zero = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    n_vec++;
    if (pstate !== 3'd4 || inc !== 1'b1 || halt !== 1'b0) begin
      n_fail++;
      $display("FAIL hlt_oaddr: got pstate=%0d inc=%b halt=%b, want 4 1 0", pstate, inc, halt);
    end
    for (int i = 0; i < 11; i++) begin
      tick();
      n_vec++;
      if (pstate !== 3'd0 || w_obs !== HALTED_OBS || w_obs !== exp_ctrl(m_ph, m_hq, op, zero)) begin
        n_fail++;
        $display("FAIL halted cyc=%0d: got pstate=%0d ctrl=%b, want pstate=0 ctrl=%b", i, pstate, w_obs, HALTED_OBS);
      end
      mem_rdy = 1'($urandom); zero = 1'($urandom);
    end
    go = 1'b1;
    tick();
    go = 1'b0; op = 5'd2; mem_rdy = 1'b1;
    n_vec++;
    if (pstate !== 3'd0 || halt !== 1'b0 || w_obs !== exp_ctrl(m_ph, m_hq, op, zero)) begin
      n_fail++;
      $display("FAIL go_release: got pstate=%0d halt=%b, want 0 0", pstate, halt);
    end
    tick();
    n_vec++;
    if (pstate !== 3'd1 || halt !== 1'b0) begin
      n_fail++;
      $display("FAIL go_resume: got pstate=%0d halt=%b, want 1 0", pstate, halt);
    end
  endtask

  task automatic test_illegal();
    logic [W-1:0] ops [2];
    ops[0] = 5'b01010;
    ops[1] = 5'b10000;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      op = ops[k]; zero = 1'b1;
      for (int i = 1; i <= 8; i++) begin
        mem_rdy = (m_ph < 4);
        tick();
        n_vec++;
        if (pstate !== 3'(i % 8) || illegal !== (i % 8 == 4) || halt !== 1'b0 ||
            (ld_acc | wr | ld_pc | dout_en) !== 1'b0 || inc !== (i % 8 == 4) ||
            w_obs !== exp_ctrl(m_ph, m_hq, op, zero)) begin
          n_fail++;
          $display("FAIL illegal op=%b i=%0d: got pstate=%0d ctrl=%b, want pstate=%0d ctrl=%b",
                   op, i, pstate, w_obs, i % 8, exp_ctrl(m_ph, m_hq, op, zero));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    op = 5'd2; mem_rdy = 1'b1; zero = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    mem_rdy = 1'b0;
    tick(); tick();
    n_vec++;
    if (pstate !== 3'd5) begin
      n_fail++;
      $display("FAIL stall_hold: got pstate=%0d, want 5", pstate);
    end
    rst = 1'b1; go = 1'b1;
    tick();
    rst = 1'b0; go = 1'b0;
    n_vec++;
    if (pstate !== 3'd0 || w_obs !== RESET_OBS) begin
      n_fail++;
      $display("FAIL reset_stall: got pstate=%0d ctrl=%b, want 0 %b", pstate, w_obs, RESET_OBS);
    end
    op = 5'd0; mem_rdy = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; op = 5'd2;
    n_vec++;
    if (pstate !== 3'd0 || halt !== 1'b0 || w_obs !== RESET_OBS) begin
      n_fail++;
      $display("FAIL reset_halt: got pstate=%0d halt=%b, want 0 0", pstate, halt);
    end
    tick();
    n_vec++;
    if (pstate !== 3'd1) begin
      n_fail++;
      $display("FAIL reset_halt_run: got pstate=%0d, want 1", pstate);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if (m_ph <= 2 || m_hq) begin
        op = W'($urandom_range(0, 7));
        if ($urandom_range(0, 4) == 0) op[4:3] = 2'($urandom_range(1, 3));
      end
      rst     = ($urandom_range(0, 99) == 0);
      go      = ($urandom_range(0, 3) == 0);
      mem_rdy = ($urandom_range(0, 9) < 7);
      zero    = 1'($urandom);
      tick();
      n_vec++;
      if (pstate !== 3'(m_ph) || w_obs !== exp_ctrl(m_ph, m_hq, op, zero)) begin
        n_fail++;
        $display("FAIL random i=%0d op=%b: got pstate=%0d ctrl=%b, want pstate=%0d ctrl=%b",
                 i, op, pstate, w_obs, m_ph, exp_ctrl(m_ph, m_hq, op, zero));
      end
    end
    rst = 1'b0; go = 1'b0;
  endtask

  initial begin
    rst = 1'b1; zero = 1'b0; mem_rdy = 1'b1; go = 1'b0; op = '0;
    test_reset();
    test_add_run();
    test_skz();
    test_sto_stall();
    test_halt();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mcu_sequencer.md
# mcu_sequencer

Parametrised instruction sequencer for the 8-bit CISC MCU. It replaces the purely combinational control decode with an owned phase register, a memory-ready wait-state handshake, a latched halt with restart, and opcode-width generalisation with illegal-opcode flagging. It sits between the instruction register and the datapath (accumulator, MDR, PC, address mux, memory strobes). It drives every datapath load, enable and strobe each cycle.

## Interface
- `OP_W`, default 3: opcode width. Values 0–7 are defined; any non-zero bit above bit 2 makes the opcode illegal.
- `MEM_WAIT_EN`, default 1: 1 means memory phases stall until `mem_rdy`; 0 means `mem_rdy` is ignored.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `op`, in, OP_W: opcode from the IR. Valid from phase IDLE to end of instruction.
- `zero`, in, 1: accumulator-zero flag.
- `mem_rdy`, in, 1: memory read data valid, or write accepted.
- `go`, in, 1: restart pulse; leaves the halted condition.
- `sel`, out, 1: address mux (1 = PC, 0 = IR operand).
- `rd`, `wr`, out, 1: memory strobes.
- `ld_ir`, `ld_acc`, `ld_mdr`, `ld_pc`, `inc`, `dout_en`, out, 1: datapath controls.
- `halt`, out, 1: high while halted.
- `illegal`, out, 1: one-cycle flag.
- `pstate`, out, 3: current phase, for debug.

## Operation
- Opcodes:
  - HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
  - ALUOP = ADD, AND, XOR or LDA.
- Phases, one per cycle, advancing 0→7→0: IADDR(0), IFETCH(1), ILOAD(2), IDLE(3), OADDR(4), OFETCH(5), ALU(6), STORE(7).
- Outputs are a decode of registered phase, `op` and `zero`:
  - `sel`: IADDR, IFETCH, ILOAD, IDLE.
  - `rd`:
    - IFETCH, ILOAD, IDLE;
    - OFETCH, ALU, STORE when ALUOP.
  - `ld_ir`: ILOAD, IDLE.
  - `ld_mdr`:
    - ILOAD;
    - ALU when ALUOP.
  - `inc`:
    - OADDR always;
    - ALU when SKZ and `zero`.
  - `ld_pc`: ALU and STORE when JMP.
  - `ld_acc`: STORE when ALUOP.
  - `dout_en`: ALU and STORE when STO.
  - `wr`: STORE when STO.
- Wait states (MEM_WAIT_EN=1):
  - The phase holds while `mem_rdy`=0 in IFETCH, in OFETCH when ALUOP, and in STORE when STO.
  - Outputs stay constant during a stall.
- Halt:
  - In OADDR with HLT, the block sets `halt_q` and enters IADDR frozen.
  - While halted, all outputs are 0 except `halt`=1 and `sel`=1, and `inc` is suppressed.
  - `go`=1 clears `halt_q`. Fetch resumes at IADDR on the next cycle.
  - `go` while not halted is ignored.
- Illegal opcode (OP_W>3, upper bits ≠0):
  - Executes as a NOP: no `ld_acc`, `ld_pc`, `wr`, `dout_en`, or `rd` in phases 5–7.
  - `inc` still fires in OADDR.
  - `illegal`=1 in OADDR only.
- Reset:
  - Phase=IADDR, `halt_q`=0.
  - Outputs are therefore `sel`=1, all others 0, `pstate`=0.
  - Reset mid-stall or mid-halt wins over `mem_rdy` and `go`.

## Timing
- Nominal instruction length is 8 cycles. Add one cycle per stalled cycle of `mem_rdy`=0.
- `pstate` updates on the clock edge. Outputs are valid in the same cycle as `pstate`, with no extra latency.
- `zero` is sampled only during ALU; changes in other phases have no effect.
- `op` is sampled from IDLE onward. A change during phases 0–2 has no effect on control.
- `mem_rdy` and `go` are evaluated at the rising edge. If `go` and `rst` are high together, reset takes precedence.
- HLT: `halt` rises the cycle after OADDR.

## Structure
- Shared package `mcu_pkg`: opcode constants, phase constants (3-bit), and the ALUOP set helper. The package is shared with the datapath and the benches.
- Sub-module `mcu_ctrl_decode`: purely combinational map from phase, `op`, `zero` and `halt_q` to the nine controls.
- The top level holds the phase register, the `halt_q` flag, the stall logic and the illegal check.

## Test plan
- Reset then free run with `op`=ADD, `mem_rdy`=1 → `pstate` cycles 0..7. `ld_acc`=1 only at phase 7; `rd`=1 at phases 1–3 and 5–7.
- SKZ, `zero`=1 at ALU → `inc`=1 at phases 4 and 6. Repeat with `zero`=0 → `inc` only at phase 4.
- STO with `mem_rdy` low for 3 cycles in STORE → `pstate` holds 7 for 4 cycles with `wr`=`dout_en`=1 throughout. The next instruction starts at 0.
- HLT → `halt`=1 and `pstate`=0 frozen for 10 cycles. Pulse `go` → phase 1 on the following cycle.
- OP_W=5, `op`=5'b01010 → `illegal` pulses at phase 4. No `ld_acc`, `wr`, or `ld_pc` is asserted.
- `rst` asserted at phase 5 during a stall → next cycle `pstate`=0, `sel`=1, all other outputs 0.
